morse_symbol_assembler: RTL and testbench

- Sits directly downstream of the press classifier and consumes its `valid`/`is_long` pulse stream (dot/dash).
- Groups symbols into one Morse character by measuring release-gap time at 100 kHz.
- Emits a character record (pattern, length, error) on letter gap, and a one-cycle word-gap marker on the longer word gap.
- Output feeds the text/display stage.

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_symbol_assembler_if.sv | 28 ++
 rtl/morse_ascii_lut.sv | 53 +++++
 rtl/morse_symbol_assembler.sv | 162 ++++++++++++++++
 tb/tb_morse_symbol_assembler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse symbol assembler.
package morse_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWaitWord
  } state_e;

  // Defaults assume a 100 kHz tick: 700 ms letter gap, 1.5 s word gap.
  localparam int unsigned LETTER_GAP_TH = 70000;
  localparam int unsigned WORD_GAP_TH   = 150000;
  localparam int unsigned MAX_SYM       = 5;

  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_symbol_assembler_if.sv
// Symbol-in / character-out bundle between the press classifier, the assembler and the text stage.
interface morse_symbol_assembler_if #(
  parameter int unsigned MAX_SYM = morse_pkg::MAX_SYM
);
  localparam int unsigned LenW = $clog2(MAX_SYM + 1);

  logic            btn_in;
  logic            sym_valid;
  logic            sym_is_long;
  logic            char_valid;
  logic [MAX_SYM-1:0] char_pattern;
  logic [LenW-1:0] char_len;
  logic            char_err;
  logic [7:0]      char_ascii;
  logic            word_gap;
  logic            busy;

  modport master (
    output btn_in, sym_valid, sym_is_long,
    input  char_valid, char_pattern, char_len, char_err, char_ascii, word_gap, busy
  );

  modport slave (
    input  btn_in, sym_valid, sym_is_long,
    output char_valid, char_pattern, char_len, char_err, char_ascii, word_gap, busy
  );

endinterface

// File: rtl/morse_ascii_lut.sv
// Combinational (len, pattern) -> ASCII decode; bit 0 is the first symbol, 1 = dash.
module morse_ascii_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [4:0] pattern,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    case ({len, pattern})
      {3'd2, 5'b00010}: ascii = 8'h41; // A
      {3'd4, 5'b00001}: ascii = 8'h42; // B
      {3'd4, 5'b00101}: ascii = 8'h43; // C
      {3'd3, 5'b00001}: ascii = 8'h44; // D
      {3'd1, 5'b00000}: ascii = 8'h45; // E
      {3'd4, 5'b00100}: ascii = 8'h46; // F
      {3'd3, 5'b00011}: ascii = 8'h47; // G
      {3'd4, 5'b00000}: ascii = 8'h48; // H
      {3'd2, 5'b00000}: ascii = 8'h49; // I
      {3'd4, 5'b01110}: ascii = 8'h4A; // J
      {3'd3, 5'b00101}: ascii = 8'h4B; // K
      {3'd4, 5'b00010}: ascii = 8'h4C; // L
      {3'd2, 5'b00011}: ascii = 8'h4D; // M
      {3'd2, 5'b00001}: ascii = 8'h4E; // N
      {3'd3, 5'b00111}: ascii = 8'h4F; // O
      {3'd4, 5'b00110}: ascii = 8'h50; // P
      {3'd4, 5'b01011}: ascii = 8'h51; // Q
      {3'd3, 5'b00010}: ascii = 8'h52; // R
      {3'd3, 5'b00000}: ascii = 8'h53; // S
      {3'd1, 5'b00001}: ascii = 8'h54; // T
      {3'd3, 5'b00100}: ascii = 8'h55; // U
      {3'd4, 5'b01000}: ascii = 8'h56; // V
      {3'd3, 5'b00110}: ascii = 8'h57; // W
      {3'd4, 5'b01001}: ascii = 8'h58; // X
      {3'd4, 5'b01101}: ascii = 8'h59; // Y
      {3'd4, 5'b00011}: ascii = 8'h5A; // Z
      {3'd5, 5'b11111}: ascii = 8'h30; // 0
      {3'd5, 5'b11110}: ascii = 8'h31; // 1
      {3'd5, 5'b11100}: ascii = 8'h32; // 2
      {3'd5, 5'b11000}: ascii = 8'h33; // 3
      {3'd5, 5'b10000}: ascii = 8'h34; // 4
      {3'd5, 5'b00000}: ascii = 8'h35; // 5
      {3'd5, 5'b00001}: ascii = 8'h36; // 6
      {3'd5, 5'b00011}: ascii = 8'h37; // 7
      {3'd5, 5'b00111}: ascii = 8'h38; // 8
      {3'd5, 5'b01111}: ascii = 8'h39; // 9
      default:          ascii = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_symbol_assembler.sv
// Groups dot/dash pulses into characters using release-gap timing; emits word-gap markers.
// Define MORSE_ASCII_DECODE_EN to build the ASCII decode on char_ascii (otherwise tied to 0).
module morse_symbol_assembler
  import morse_pkg::*;
#(
  parameter int unsigned LETTER_GAP_TH = morse_pkg::LETTER_GAP_TH,
  parameter int unsigned WORD_GAP_TH   = morse_pkg::WORD_GAP_TH,
  parameter int unsigned MAX_SYM       = morse_pkg::MAX_SYM
) (
  input logic                     clk,
  input logic                     rst,
  morse_symbol_assembler_if.slave bus
);

  localparam int unsigned CntW = $clog2(WORD_GAP_TH + 1);
  localparam int unsigned LenW = $clog2(MAX_SYM + 1);
  localparam logic [CntW-1:0] LetterLast = CntW'(LETTER_GAP_TH - 1);
  localparam logic [CntW-1:0] WordLast   = CntW'(WORD_GAP_TH - 1);
  localparam logic [CntW-1:0] CntMax     = CntW'(WORD_GAP_TH);
  localparam logic [LenW-1:0] LenMax     = LenW'(MAX_SYM);

  state_e             state_q, state_d;
  logic [CntW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [MAX_SYM-1:0] shift_q, shift_d;
  logic [LenW-1:0]    len_q, len_d;
  logic               err_q, err_d;
  logic               char_valid_q, char_valid_d;
  logic               word_gap_q, word_gap_d;
  logic [MAX_SYM-1:0] pat_out_q, pat_out_d;
  logic [LenW-1:0]    len_out_q, len_out_d;
  logic               err_out_q, err_out_d;
  logic               quiet;

  // A cycle only counts toward a gap when the button is released and no symbol arrives.
  assign quiet = !bus.sym_valid && !bus.btn_in;

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    shift_d      = shift_q;
    len_d        = len_q;
    err_d        = err_q;
    char_valid_d = 1'b0;
    word_gap_d   = 1'b0;
    pat_out_d    = pat_out_q;
    len_out_d    = len_out_q;
    err_out_d    = err_out_q;

    if (!quiet) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != CntMax) begin
      gap_cnt_d = gap_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        gap_cnt_d = '0;
        if (bus.sym_valid) begin
          shift_d = MAX_SYM'(bus.sym_is_long);
          len_d   = LenW'(1);
          err_d   = 1'b0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (bus.sym_valid) begin
          if (len_q < LenMax) begin
            for (int unsigned i = 0; i < MAX_SYM; i++) begin
              if (LenW'(i) == len_q) shift_d[i] = bus.sym_is_long;
            end
            len_d = len_q + LenW'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (quiet && gap_cnt_q == LetterLast) begin
          char_valid_d = 1'b1;
          pat_out_d    = shift_q;
          len_out_d    = len_q;
          err_out_d    = err_q;
          state_d      = StWaitWord;
        end
      end
      StWaitWord: begin
        if (bus.sym_valid) begin
          shift_d = MAX_SYM'(bus.sym_is_long);
          len_d   = LenW'(1);
          err_d   = 1'b0;
          state_d = StCollect;
        end else if (quiet && gap_cnt_q == WordLast) begin
          word_gap_d = 1'b1;
          gap_cnt_d  = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      char_valid_q <= 1'b0;
      word_gap_q   <= 1'b0;
      pat_out_q    <= '0;
      len_out_q    <= '0;
      err_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      err_q        <= err_d;
      char_valid_q <= char_valid_d;
      word_gap_q   <= word_gap_d;
      pat_out_q    <= pat_out_d;
      len_out_q    <= len_out_d;
      err_out_q    <= err_out_d;
    end
  end

`ifdef MORSE_ASCII_DECODE_EN
  logic [7:0] lut_ascii;
  logic [7:0] ascii_q, ascii_d;

  morse_ascii_lut u_ascii_lut (
    .len    (3'(len_q)),
    .pattern(5'(shift_q)),
    .ascii  (lut_ascii)
  );

  always_comb begin
    ascii_d = ascii_q;
    if (char_valid_d) begin
      ascii_d = (err_q || (32'(len_q) > 32'd5)) ? ASCII_UNKNOWN : lut_ascii;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_q <= 8'h00;
    end else begin
      ascii_q <= ascii_d;
    end
  end

  assign bus.char_ascii = ascii_q;
`else
  assign bus.char_ascii = 8'h00;
`endif

  assign bus.char_valid   = char_valid_q;
  assign bus.char_pattern = pat_out_q;
  assign bus.char_len     = len_out_q;
  assign bus.char_err     = err_out_q;
  assign bus.word_gap     = word_gap_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Bench for morse_symbol_assembler: vector table, directed corner sequences, random vs. model.
module tb_morse_symbol_assembler;

  localparam int unsigned LG = 20;
  localparam int unsigned WG = 50;
  localparam int unsigned MS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_symbol_assembler_if #(.MAX_SYM(MS)) bus ();

  morse_symbol_assembler #(
    .LETTER_GAP_TH(LG),
    .WORD_GAP_TH  (WG),
    .MAX_SYM      (MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         n;
    logic [7:0] syms;
    logic [4:0] pat;
    int         len;
    bit         err;
    logic [7:0] ascii;
  } vec_t;

  vec_t vecs[7];

  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                     "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  // Reference model: list of symbols of the open character and quiet time since last activity.
  bit         m_syms[$];
  bit         m_in_char, m_wait_word;
  int         m_idle;
  bit         e_cv, e_wg, e_err;
  logic [4:0] e_pat;
  int         e_len;
  logic [7:0] e_ascii;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_if_en(input logic [7:0] a);
`ifdef MORSE_ASCII_DECODE_EN
    return a;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] ref_ascii();
    string s;
    s = "";
    if (m_syms.size() > MS) return 8'h3F;
    foreach (m_syms[i]) begin
      if (m_syms[i]) s = {s, "-"};
      else s = {s, "."};
    end
    for (int k = 0; k < 36; k++) begin
      if (s == tbl[k]) return (k < 26) ? 8'(65 + k) : 8'(48 + k - 26);
    end
    return 8'h3F;
  endfunction

  function automatic void model_reset();
    m_syms.delete();
    m_in_char   = 1'b0;
    m_wait_word = 1'b0;
    m_idle      = 0;
    e_cv        = 1'b0;
    e_wg        = 1'b0;
    e_err       = 1'b0;
    e_pat       = '0;
    e_len       = 0;
    e_ascii     = 8'h00;
  endfunction

  function automatic void model_edge(input bit btn, input bit sv, input bit sl);
    e_cv = 1'b0;
    e_wg = 1'b0;
    if (sv) begin
      if (!m_in_char) begin
        m_syms.delete();
        m_in_char   = 1'b1;
        m_wait_word = 1'b0;
      end
      m_syms.push_back(sl);
      m_idle = 0;
    end else if (btn) begin
      m_idle = 0;
    end else begin
      if (m_idle < WG) m_idle++;
      if (m_in_char && m_idle == LG) begin
        e_cv    = 1'b1;
        e_err   = (m_syms.size() > MS);
        e_len   = e_err ? MS : m_syms.size();
        e_pat   = '0;
        for (int i = 0; i < e_len; i++) e_pat[i] = m_syms[i];
        e_ascii = ascii_if_en(ref_ascii());
        m_in_char   = 1'b0;
        m_wait_word = 1'b1;
      end else if (m_wait_word && m_idle == WG) begin
        e_wg        = 1'b1;
        m_wait_word = 1'b0;
      end
    end
  endfunction

  task automatic compare_model();
    chk("char_valid", bus.char_valid, e_cv);
    chk("word_gap", bus.word_gap, e_wg);
    chk("busy", bus.busy, m_in_char || m_wait_word);
    chk("char_pattern", bus.char_pattern, e_pat);
    chk("char_len", bus.char_len, e_len);
    chk("char_err", bus.char_err, e_err);
    chk("char_ascii", bus.char_ascii, e_ascii);
  endtask

  task automatic step(input bit btn, input bit sv, input bit sl);
    @(negedge clk);
    bus.btn_in      = btn;
    bus.sym_valid   = sv;
    bus.sym_is_long = sl;
    @(posedge clk);
    model_edge(btn, sv, sl);
    #1;
    compare_model();
  endtask

  task automatic send_char(input int n, input logic [7:0] syms);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, syms[i]);
    end
  endtask

  // Idle until char_valid (bounded); n = edges waited, wgs = word_gap pulses seen meanwhile.
  task automatic wait_cv(input int max, output int n, output int wgs);
    n   = 0;
    wgs = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
      if (bus.word_gap === 1'b1) wgs++;
    end while (bus.char_valid !== 1'b1 && n < max);
  endtask

  task automatic wait_wg(input int max, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while (bus.word_gap !== 1'b1 && n < max);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wgs, hits, ns, pre, post;
    bus.btn_in      = 1'b0;
    bus.sym_valid   = 1'b0;
    bus.sym_is_long = 1'b0;
    vecs[0] = '{2, 8'b0000_0010, 5'b00010, 2, 1'b0, 8'h41}; // A
    vecs[1] = '{1, 8'b0000_0000, 5'b00000, 1, 1'b0, 8'h45}; // E
    vecs[2] = '{4, 8'b0000_1011, 5'b01011, 4, 1'b0, 8'h51}; // Q
    vecs[3] = '{6, 8'b0000_0000, 5'b00000, 5, 1'b1, 8'h3F}; // six dots
    vecs[4] = '{5, 8'b0000_0011, 5'b00011, 5, 1'b0, 8'h37}; // 7
    vecs[5] = '{4, 8'b0000_1100, 5'b01100, 4, 1'b0, 8'h3F}; // ..-- unknown
    vecs[6] = '{7, 8'b0111_1111, 5'b11111, 5, 1'b1, 8'h3F}; // seven dashes

    model_reset();
    #2;
    compare_model();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      send_char(vecs[v].n, vecs[v].syms);
      wait_cv(LG + 10, n, wgs);
      chk("tbl_latency", n, LG);
      chk("tbl_pattern", bus.char_pattern, vecs[v].pat);
      chk("tbl_len", bus.char_len, vecs[v].len);
      chk("tbl_err", bus.char_err, vecs[v].err);
      chk("tbl_ascii", bus.char_ascii, ascii_if_en(vecs[v].ascii));
      wait_wg(WG, n);
      chk("tbl_word_latency", n, WG - LG);
      chk("tbl_busy_after_word", bus.busy, 1'b0);
    end

    // Button held mid-gap freezes the gap timer.
    step(1'b0, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    hits = 0;
    repeat (100) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.char_valid === 1'b1) hits++;
    end
    chk("hold_no_char", hits, 0);
    step(1'b0, 1'b1, 1'b1);
    wait_cv(LG + 10, n, wgs);
    chk("hold_latency", n, LG);
    chk("hold_len", bus.char_len, 2);
    chk("hold_pattern", bus.char_pattern, 5'b00011);
    chk("hold_ascii", bus.char_ascii, ascii_if_en(8'h4D));
    wait_wg(WG, n);

    // New symbol during the word wait suppresses word_gap.
    step(1'b0, 1'b1, 1'b0);
    wait_cv(LG + 10, n, wgs);
    chk("ww_first_ascii", bus.char_ascii, ascii_if_en(8'h45));
    repeat (9) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    wait_cv(LG + 10, n, wgs);
    chk("ww_no_word_gap", wgs, 0);
    chk("ww_latency", n, LG);
    chk("ww_len", bus.char_len, 1);
    chk("ww_pattern", bus.char_pattern, 5'b00001);
    wait_wg(WG, n);

    // Symbol arriving exactly when the gap threshold would fire.
    step(1'b0, 1'b1, 1'b0);
    repeat (LG - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("thr_no_char", bus.char_valid, 1'b0);
    wait_cv(LG + 10, n, wgs);
    chk("thr_latency", n, LG);
    chk("thr_len", bus.char_len, 2);
    chk("thr_pattern", bus.char_pattern, 5'b00010);
    wait_wg(WG, n);

    // Asynchronous reset mid-character.
    send_char(3, 8'b0000_0101);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_char_valid", bus.char_valid, 1'b0);
    chk("rst_pattern", bus.char_pattern, 5'b00000);
    chk("rst_len", bus.char_len, 0);
    chk("rst_err", bus.char_err, 1'b0);
    chk("rst_ascii", bus.char_ascii, 8'h00);
    chk("rst_word_gap", bus.word_gap, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    hits = 0;
    wgs  = 0;
    repeat (LG + WG + 5) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.char_valid === 1'b1) hits++;
      if (bus.word_gap === 1'b1) wgs++;
    end
    chk("rst_no_char", hits, 0);
    chk("rst_no_word", wgs, 0);
    step(1'b0, 1'b1, 1'b0);
    wait_cv(LG + 10, n, wgs);
    chk("rst_fresh_len", bus.char_len, 1);
    chk("rst_fresh_err", bus.char_err, 1'b0);
    chk("rst_fresh_latency", n, LG);
    wait_wg(WG, n);

    // Random characters, gaps and button holds, checked every cycle by the model.
    repeat (80) begin
      ns = $urandom_range(1, 7);
      for (int i = 0; i < ns; i++) begin
        pre = $urandom_range(1, 6);
        repeat (pre) step($urandom_range(0, 3) == 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end
      case ($urandom_range(0, 3))
        0:       post = $urandom_range(LG - 3, LG + 2);
        1:       post = $urandom_range(WG - 3, WG + 2);
        default: post = $urandom_range(0, WG + 10);
      endcase
      repeat (post) step($urandom_range(0, 15) == 0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
